// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
//   Constants and types shared by the video RAM writer and the scanout block.
//   Contents:
//     VRAM_AW / VRAM_WORDS  - word-address width and size of the 16-bit VRAM
//     vram_state_e          - writer state machine encoding
//     BE_HI / BE_LO / BE_WORD - byte-enable patterns for the RAM write port
//     lane_be()             - maps a CPU byte address LSB onto a byte lane
// ---------------------------------------------------------------------------
package vram_pkg;

  localparam int VRAM_AW    = 14;
  localparam int VRAM_WORDS = 1 << VRAM_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2
  } vram_state_e;

  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_WORD = 2'b11;

  // The RAM is big-endian: the even byte of a word lives in bits 15:8.
  function automatic logic [1:0] lane_be(input logic byte_sel);
    return byte_sel ? BE_LO : BE_HI;
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// ---------------------------------------------------------------------------
// vram_writer_if
//   Bundles the CPU byte-write bus and the RAM write port of the VRAM writer.
//   Signals:
//     cpu_we    - byte write strobe (taken when cpu_ready=1)
//     cpu_addr  - 15-bit byte address inside the 32 KB screen area
//     cpu_din   - write byte
//     cpu_ready - writer can take a byte this cycle
//     ram_we    - RAM write enable
//     ram_be    - byte enables, [1]=bits 15:8, [0]=bits 7:0
//     ram_addr  - RAM word address
//     ram_din   - RAM write data
//   Modports:
//     master - the CPU/RAM environment around the writer
//     slave  - the vram_writer itself
// ---------------------------------------------------------------------------
interface vram_writer_if
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW
);

  logic          cpu_we;
  logic [14:0]   cpu_addr;
  logic [7:0]    cpu_din;
  logic          cpu_ready;

  logic          ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;

  modport master (
    output cpu_we, cpu_addr, cpu_din,
    input  cpu_ready,
    input  ram_we, ram_be, ram_addr, ram_din
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_din,
    output cpu_ready,
    output ram_we, ram_be, ram_addr, ram_din
  );

endinterface

// File: rtl/vram_wfifo.sv
// ---------------------------------------------------------------------------
// vram_wfifo
//   Small synchronous FIFO that buffers pending VRAM writes.
//   Ports:
//     clk, reset - clock and asynchronous active-high reset
//     push, din  - write an entry (ignored when full)
//     pop        - drop the head entry (ignored when empty)
//     dout       - head entry, valid whenever empty=0
//     count      - number of stored entries (0..DEPTH)
//     full/empty - occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vram_wfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array carries no reset; stale contents are never visible
  // because dout is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; a push and pop on the same edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_writer.sv
// ---------------------------------------------------------------------------
// vram_writer
//   Write side of the 16-bit video RAM. CPU byte writes are queued in a small
//   FIFO and drained into the RAM only in cycles the scanout leaves free. A
//   fill engine can overwrite every word of the RAM with one 16-bit pattern.
//   Ports:
//     clk, reset  - clock and asynchronous active-high reset
//     bus         - CPU byte-write bus and RAM write port (slave modport)
//     fill_start  - one-cycle pulse requesting a fill (taken in IDLE only)
//     fill_data   - fill pattern, captured with an accepted fill_start
//     fill_busy   - flush or fill in progress
//     fill_done   - one-cycle pulse alongside the last fill write
//     vid_busy    - scanout owns the RAM port in the next cycle
// ---------------------------------------------------------------------------
module vram_writer
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(VRAM_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  vram_writer_if.slave    bus,
  input  logic            fill_start,
  input  logic [15:0]     fill_data,
  output logic            fill_busy,
  output logic            fill_done,
  input  logic            vid_busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + 2 + 16;
  localparam logic [AW-1:0] FILL_LAST = '1;

  vram_state_e   state_q;
  vram_state_e   state_d;
  logic [AW-1:0] fill_cnt_q;
  logic [AW-1:0] fill_cnt_d;
  logic [15:0]   fill_pat_q;
  logic [15:0]   fill_pat_d;
  logic          fill_done_q;
  logic          fill_done_d;

  logic          ram_we_q;
  logic          ram_we_d;
  logic [1:0]    ram_be_q;
  logic [1:0]    ram_be_d;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] ram_addr_d;
  logic [15:0]   ram_din_q;
  logic [15:0]   ram_din_d;

  logic          cpu_ready;
  logic          push;
  logic          pop;
  logic          slot;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;
  logic [AW-1:0] head_addr;
  logic [1:0]    head_be;
  logic [15:0]   head_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  // The scanout raises vid_busy the cycle before it reads, so a low vid_busy
  // means the edge ending this cycle may launch a RAM write.
  assign slot = !vid_busy;

  assign cpu_ready  = !full && (state_q == ST_IDLE);
  assign push       = bus.cpu_we && cpu_ready;
  assign push_entry = {bus.cpu_addr[AW:1], lane_be(bus.cpu_addr[0]),
                       bus.cpu_din, bus.cpu_din};
  assign {head_addr, head_be, head_data} = head;

  vram_wfifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Next-state and next-output logic. CPU entries drain in IDLE and FLUSH;
  // FILL owns every slot until the last word has been written.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    fill_pat_d  = fill_pat_q;
    fill_done_d = 1'b0;
    ram_we_d    = 1'b0;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    pop         = 1'b0;

    if ((state_q != ST_FILL) && slot && !empty) begin
      pop        = 1'b1;
      ram_we_d   = 1'b1;
      ram_be_d   = head_be;
      ram_addr_d = head_addr;
      ram_din_d  = head_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d    = ST_FLUSH;
          fill_pat_d = fill_data;
        end
      end
      ST_FLUSH: begin
        if (count == '0) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (slot) begin
          ram_we_d   = 1'b1;
          ram_be_d   = BE_WORD;
          ram_addr_d = fill_cnt_q;
          ram_din_d  = fill_pat_q;
          fill_cnt_d = fill_cnt_q + 1'b1;
          // Leave on the last word so the counter never wraps inside FILL.
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = ST_IDLE;
            fill_done_d = 1'b1;
            fill_cnt_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops ram_we straight away and
  // abandons any fill in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      fill_pat_q  <= '0;
      fill_done_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_pat_q  <= fill_pat_d;
      fill_done_q <= fill_done_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_be    = ram_be_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign fill_busy     = (state_q != ST_IDLE);
  assign fill_done     = fill_done_q;

endmodule
